// File: rtl/mdu_types.sv
// mdu_types: shared widths, opcode/state enums and uop record for the MDU functional unit
package mdu_types;
  localparam int XLEN = 32;
  localparam int ROB_IDX = 5;
  localparam int PRF_IDX = 6;
  localparam int ARCH_IDX = 5;
  localparam int DIV_ITERS = XLEN;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} mdu_state_t;
  typedef struct packed {
    logic [ROB_IDX-1:0]  rob_id;
    logic [PRF_IDX-1:0]  rd_phy;
    logic [ARCH_IDX-1:0] rd_arch;
    mdu_op_t             fu_opcode;
    logic [XLEN-1:0]     rs1_value;
    logic [XLEN-1:0]     rs2_value;
  } fu_mdu_reg_t;
endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: unsigned restoring radix-2 divider, one quotient bit per cycle
module mdu_divider
  import mdu_types::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);
  localparam int CW = $clog2(DIV_ITERS);
  localparam logic [CW-1:0] LAST = CW'(DIV_ITERS - 1);
  logic [CW-1:0] cnt;
  logic busy;
  logic [XLEN-1:0] rem, quo, dvs, rem_n, quo_n;
  logic [XLEN:0] sh, diff;
  assign sh = {rem, quo[XLEN-1]};
  assign diff = sh - {1'b0, dvs};
  assign rem_n = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_n = {quo[XLEN-2:0], ~diff[XLEN]};
  // outputs are the post-step values so the caller can latch them on the final step
  assign quotient = quo_n;
  assign remainder = rem_n;
  assign done = busy && cnt == LAST;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      busy <= 1'b0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (start) begin
      cnt <= '0;
      busy <= 1'b1;
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      busy <= !done;
      rem <= rem_n;
      quo <= quo_n;
    end
  end
endmodule

// File: rtl/fu_mdu.sv
// fu_mdu: RV32M multiply/divide unit; single-cycle MUL*, 32-cycle DIV/REM, CDB result with backpressure
module fu_mdu
  import mdu_types::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rs_valid,
  output logic                mdu_ready,
  input  logic [ROB_IDX-1:0]  rob_id,
  input  logic [PRF_IDX-1:0]  rd_phy,
  input  logic [ARCH_IDX-1:0] rd_arch,
  input  logic [2:0]          fu_opcode,
  input  logic [XLEN-1:0]     rs1_value,
  input  logic [XLEN-1:0]     rs2_value,
  output logic                cdb_valid,
  input  logic                cdb_ready,
  output logic [ROB_IDX-1:0]  cdb_rob_id,
  output logic [PRF_IDX-1:0]  cdb_rd_phy,
  output logic [ARCH_IDX-1:0] cdb_rd_arch,
  output logic [XLEN-1:0]     cdb_rd_value
);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  mdu_state_t state, state_n;
  fu_mdu_reg_t uop;
  logic [XLEN-1:0] result, special_val, dvd, dvs, quo, rem, mul_res, div_res;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [2:0] op;
  logic accept, sgn_in, special, div_start, div_done, s1, s2, neg_q, neg_r;
  assign mdu_ready = state == S_IDLE;
  assign accept = rs_valid && mdu_ready;
  assign sgn_in = !fu_opcode[0];
  assign special = rs2_value == '0 || (sgn_in && rs1_value == INT_MIN && rs2_value == '1);
  assign special_val = rs2_value == '0 ? (fu_opcode[1] ? rs1_value : '1)
                                       : (fu_opcode[1] ? '0 : INT_MIN);
  assign dvd = sgn_in && rs1_value[XLEN-1] ? -rs1_value : rs1_value;
  assign dvs = sgn_in && rs2_value[XLEN-1] ? -rs2_value : rs2_value;
  assign op = uop.fu_opcode;
  // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed
  assign s1 = (op[1] ^ op[0]) && uop.rs1_value[XLEN-1];
  assign s2 = op[1:0] == 2'b01 && uop.rs2_value[XLEN-1];
  assign mul_a = {{XLEN{s1}}, uop.rs1_value};
  assign mul_b = {{XLEN{s2}}, uop.rs2_value};
  assign prod = mul_a * mul_b;
  assign mul_res = op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign neg_q = !op[0] && (uop.rs1_value[XLEN-1] ^ uop.rs2_value[XLEN-1]);
  assign neg_r = !op[0] && uop.rs1_value[XLEN-1];
  assign div_res = op[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
  assign cdb_valid = state == S_DONE;
  assign cdb_rob_id = uop.rob_id;
  assign cdb_rd_phy = uop.rd_phy;
  assign cdb_rd_arch = uop.rd_arch;
  assign cdb_rd_value = result;
  mdu_divider u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (dvd),
    .divisor   (dvs),
    .quotient  (quo),
    .remainder (rem),
    .done      (div_done)
  );
  always_comb begin
    state_n = state;
    div_start = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        state_n = !fu_opcode[2] ? S_MUL : special ? S_DONE : S_DIV;
        div_start = fu_opcode[2] && !special;
      end
      S_MUL:  state_n = S_DONE;
      S_DIV:  state_n = div_done ? S_DONE : S_DIV;
      S_DONE: state_n = cdb_ready ? S_IDLE : S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      uop <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        uop <= '{rob_id: rob_id, rd_phy: rd_phy, rd_arch: rd_arch,
                 fu_opcode: mdu_op_t'(fu_opcode), rs1_value: rs1_value, rs2_value: rs2_value};
        result <= special_val;
      end
      if (state == S_MUL) result <= mul_res;
      if (state == S_DIV && div_done) result <= div_res;
    end
  end
endmodule

// File: tb/tb_fu_mdu.sv
// tb_fu_mdu: table-driven, random and hand-sequenced checks of fu_mdu against an arithmetic model
module tb_fu_mdu;
  logic clk = 1'b0;
  logic rst, rs_valid, mdu_ready, cdb_valid, cdb_ready;
  logic [4:0] rob_id, rd_arch, cdb_rob_id, cdb_rd_arch;
  logic [5:0] rd_phy, cdb_rd_phy;
  logic [2:0] fu_opcode;
  logic [31:0] rs1_value, rs2_value, cdb_rd_value;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  fu_mdu dut (
    .clk(clk), .rst(rst), .rs_valid(rs_valid), .mdu_ready(mdu_ready),
    .rob_id(rob_id), .rd_phy(rd_phy), .rd_arch(rd_arch), .fu_opcode(fu_opcode),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .cdb_valid(cdb_valid),
    .cdb_ready(cdb_ready), .cdb_rob_id(cdb_rob_id), .cdb_rd_phy(cdb_rd_phy),
    .cdb_rd_arch(cdb_rd_arch), .cdb_rd_value(cdb_rd_value)
  );
  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction
  function automatic logic [31:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    int ia = $signed(a);
    int ib = $signed(b);
    logic [63:0] p;
    logic [31:0] r;
    case (op)
      3'd0: begin p = 64'(ua * ub); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
      3'd4: r = b == 0 ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(ia / ib);
      3'd5: r = b == 0 ? 32'hFFFFFFFF : a / b;
      3'd6: r = b == 0 ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(ia % ib);
      default: r = b == 0 ? a : a % b;
    endcase
    return r;
  endfunction
  function automatic int model_lat(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
    return 33;
  endfunction
  // called at a negedge in IDLE; returns at the negedge of the IDLE cycle after the result
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    logic [4:0] rid = 5'($urandom);
    logic [5:0] pid = 6'($urandom);
    logic [4:0] aid = 5'($urandom);
    int n;
    chk({name, " ready_before"}, 32'(mdu_ready), 32'd1);
    rs_valid = 1'b1; fu_opcode = op; rs1_value = a; rs2_value = b;
    rob_id = rid; rd_phy = pid; rd_arch = aid;
    @(posedge clk);
    @(negedge clk);
    rs_valid = 1'b0; rs1_value = $urandom; rs2_value = $urandom;
    for (n = 1; n <= 60; n++) begin
      chk({name, " ready_busy"}, 32'(mdu_ready), 32'd0);
      if (cdb_valid) break;
      @(negedge clk);
    end
    chk({name, " latency"}, 32'(n), 32'(lat));
    chk({name, " value"}, cdb_rd_value, exp);
    chk({name, " rob_id"}, 32'(cdb_rob_id), 32'(rid));
    chk({name, " rd_phy"}, 32'(cdb_rd_phy), 32'(pid));
    chk({name, " rd_arch"}, 32'(cdb_rd_arch), 32'(aid));
    @(negedge clk);
    chk({name, " ready_after"}, 32'(mdu_ready), 32'd1);
    chk({name, " valid_after"}, 32'(cdb_valid), 32'd0);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v[$];
    logic [31:0] held;
    logic seen;
    v.push_back('{"mul_neg", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 2});
    v.push_back('{"mulh_min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 2});
    v.push_back('{"mulhu_max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2});
    v.push_back('{"mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 2});
    v.push_back('{"div_neg", 3'd4, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 33});
    v.push_back('{"rem_neg", 3'd6, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 33});
    v.push_back('{"divu", 3'd5, 32'd100, 32'd7, 32'd14, 33});
    v.push_back('{"remu", 3'd7, 32'd100, 32'd7, 32'd2, 33});
    v.push_back('{"divu_zero", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1});
    v.push_back('{"div_zero", 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1});
    v.push_back('{"rem_zero", 3'd6, 32'd5, 32'd0, 32'd5, 1});
    v.push_back('{"div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    v.push_back('{"rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1});
    rst = 1'b1; rs_valid = 1'b0; cdb_ready = 1'b1; fu_opcode = '0;
    rs1_value = '0; rs2_value = '0; rob_id = '0; rd_phy = '0; rd_arch = '0;
    repeat (3) @(negedge clk);
    chk("reset ready", 32'(mdu_ready), 32'd1);
    chk("reset valid", 32'(cdb_valid), 32'd0);
    chk("reset value", cdb_rd_value, 32'd0);
    chk("reset rob_id", 32'(cdb_rob_id), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    foreach (v[i]) run_op(v[i].name, v[i].op, v[i].a, v[i].b, v[i].exp, v[i].lat);
    for (int i = 0; i < 60; i++) begin
      logic [2:0] op = 3'($urandom_range(0, 7));
      logic [31:0] a = pick();
      logic [31:0] b = pick();
      run_op("random", op, a, b, model(op, a, b), model_lat(op, a, b));
    end
    // backpressure: result held while cdb_ready is low, and a pending issue is ignored
    cdb_ready = 1'b0;
    rs_valid = 1'b1; fu_opcode = 3'd0; rs1_value = 32'd6; rs2_value = 32'd7; rob_id = 5'd9;
    @(posedge clk);
    @(negedge clk);
    fu_opcode = 3'd5; rs1_value = 32'd99; rs2_value = 32'd0; rob_id = 5'd1;
    for (int n = 0; n < 5 && !cdb_valid; n++) @(negedge clk);
    held = cdb_rd_value;
    chk("bp value", held, 32'd42);
    for (int n = 0; n < 4; n++) begin
      chk("bp valid_held", 32'(cdb_valid), 32'd1);
      chk("bp value_held", cdb_rd_value, held);
      chk("bp rob_held", 32'(cdb_rob_id), 32'd9);
      chk("bp ready_low", 32'(mdu_ready), 32'd0);
      @(negedge clk);
    end
    cdb_ready = 1'b1; rs_valid = 1'b0;
    @(negedge clk);
    chk("bp idle_ready", 32'(mdu_ready), 32'd1);
    chk("bp idle_valid", 32'(cdb_valid), 32'd0);
    run_op("bp next", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
    // reset during divide iteration 10 kills the uop
    rs_valid = 1'b1; fu_opcode = 3'd4; rs1_value = 32'd1000; rs2_value = 32'd7;
    @(posedge clk);
    @(negedge clk);
    rs_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_div ready", 32'(mdu_ready), 32'd1);
    chk("rst_div valid", 32'(cdb_valid), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      seen |= cdb_valid;
      @(negedge clk);
    end
    chk("rst_div no_result", 32'(seen), 32'd0);
    run_op("post_rst div", 3'd4, 32'd1000, 32'd7, 32'd142, 33);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
